// File: rtl/fp16_pkg.sv
// Shared FP16 constants, field slices and special-operand classification for the multiplier pipeline.
package fp16_pkg;

  localparam logic [4:0]  EXP_MAX   = 5'h1F;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [14:0] FP16_INF  = 15'h7C00;

  localparam int SIGN_BIT = 15;
  localparam int EXP_HI   = 14;
  localparam int EXP_LO   = 10;
  localparam int MAN_HI   = 9;
  localparam int MAN_LO   = 0;

  typedef struct packed {
    logic        special;
    logic [15:0] val;
  } fp16_class_t;

  // Subnormals are flushed to zero, so exp==0 counts as zero regardless of mantissa.
  function automatic fp16_class_t fp16_classify(input logic [15:0] a, input logic [15:0] b);
    fp16_class_t res;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
    a_nan  = (a[EXP_HI:EXP_LO] == EXP_MAX) && (a[MAN_HI:MAN_LO] != '0);
    b_nan  = (b[EXP_HI:EXP_LO] == EXP_MAX) && (b[MAN_HI:MAN_LO] != '0);
    a_inf  = (a[EXP_HI:EXP_LO] == EXP_MAX) && (a[MAN_HI:MAN_LO] == '0);
    b_inf  = (b[EXP_HI:EXP_LO] == EXP_MAX) && (b[MAN_HI:MAN_LO] == '0);
    a_zero = (a[EXP_HI:EXP_LO] == '0);
    b_zero = (b[EXP_HI:EXP_LO] == '0);
    s      = a[SIGN_BIT] ^ b[SIGN_BIT];
    res.special = 1'b1;
    if (a_nan || b_nan) begin
      res.val = FP16_QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      res.val = FP16_QNAN;
    end else if (a_inf || b_inf) begin
      res.val = {s, FP16_INF};
    end else if (a_zero || b_zero) begin
      res.val = {s, 15'h0000};
    end else begin
      res.special = 1'b0;
      res.val     = 16'h0000;
    end
    return res;
  endfunction

endpackage

// File: rtl/fp16_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered storage, occupancy count and sync flush.
module fp16_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [W-1:0]             wr_data_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [W-1:0]             rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Valid/ready: a beat transfers on a posedge where valid and ready are both high;
  // ready depends only on registered occupancy, never on the opposite side's ready.
  assign wr_ready_o = (count_q != CW'(DEPTH));
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  assign push = wr_valid_i & wr_ready_o;
  assign pop  = rd_valid_o & rd_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale slots are never visible because the read side is gated by count.
  always_ff @(posedge clk) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/fp16_mult_issue.sv
// FP16 multiplier operand issue queue: buffers {a, b, tag}, classifies specials at enqueue, presents FWFT head.
module fp16_mult_issue
  import fp16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_a,
  input  logic [15:0]            in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_a,
  output logic [15:0]            out_b,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_special,
  output logic [15:0]            out_special_val,
  output logic [$clog2(DEPTH):0] count
);

  typedef struct packed {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [TAG_W-1:0] tag;
    fp16_class_t      cls;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t wr_entry, head;
  logic   head_valid;

  always_comb begin
    wr_entry     = '0;
    wr_entry.a   = in_a;
    wr_entry.b   = in_b;
    wr_entry.tag = in_tag;
    wr_entry.cls = fp16_classify(in_a, in_b);
  end

  fp16_sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .wr_data_i  (wr_entry),
    .rd_valid_o (head_valid),
    .rd_ready_i (out_ready),
    .rd_data_o  (head),
    .count_o    (count)
  );

  // Head fields are forced to zero whenever no entry is presented.
  assign out_valid       = head_valid;
  assign out_a           = head_valid ? head.a   : 16'h0000;
  assign out_b           = head_valid ? head.b   : 16'h0000;
  assign out_tag         = head_valid ? head.tag : '0;
  assign out_special     = head_valid & head.cls.special;
  assign out_special_val = out_special ? head.cls.val : 16'h0000;

endmodule
